// File: rtl/data_memory_responder.sv
// Word-addressed data memory serving MemRead/MemWrite strobes with programmable wait states.
// Latency: request accepted at edge N -> mem_done high WAIT_CYCLES edges later, for one cycle.
// Backpressure: mem_busy high whenever not IDLE; strobes outside IDLE are ignored, not queued.
module data_memory_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_done,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_load;
    logic              r_acc_err;
    logic [DATA_W-1:0] r_read_data;
    logic              r_done;
    logic              r_busy;
    logic              r_err_out;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req;
    logic              w_req_err;
    logic [AW-1:0]     w_req_idx;
    logic              w_sel_load;
    logic              w_sel_err;
    logic [AW-1:0]     w_sel_idx;
    logic [DATA_W-1:0] w_load_dat;
    logic              w_commit;

    assign w_req     = MemRead | MemWrite;
    assign w_req_idx = addr[AW+1:2];
    // Errors are decided from the request as presented at accept time.
    assign w_req_err = (MemRead & MemWrite) | (addr[1:0] != 2'b00) | (addr >= 32'(4 * DEPTH));

    // With zero wait states DONE is entered straight from IDLE, so the load
    // source is the live request rather than the latched copy.
    always_comb begin
        w_sel_load = r_is_load;
        w_sel_err  = r_acc_err;
        w_sel_idx  = r_idx;
        if (r_state == S_IDLE) begin
            w_sel_load = MemRead & ~MemWrite;
            w_sel_err  = w_req_err;
            w_sel_idx  = w_req_idx;
        end
        w_load_dat = '0;
        if (w_sel_load && !w_sel_err) begin
            w_load_dat = r_mem[w_sel_idx];
        end
    end

    // Stores land only as DONE hands back to IDLE, so a reset in BUSY or DONE drops them.
    assign w_commit = (r_state == S_DONE) && !r_is_load && !r_acc_err;

    // Control FSM: accept, count wait states, one-cycle completion with registered status.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_read_data <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_err_out   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done      <= 1'b0;
                    r_err_out   <= 1'b0;
                    r_read_data <= '0;
                    if (w_req) begin
                        r_idx     <= w_req_idx;
                        r_wdata   <= write_data;
                        r_is_load <= MemRead & ~MemWrite;
                        r_acc_err <= w_req_err;
                        r_cnt     <= CW'(WAIT_CYCLES);
                        r_busy    <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_err_out   <= w_sel_err;
                            r_read_data <= w_load_dat;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state     <= S_DONE;
                        r_done      <= 1'b1;
                        r_err_out   <= w_sel_err;
                        r_read_data <= w_load_dat;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_err_out   <= 1'b0;
                    r_read_data <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: not cleared by reset, written only on a clean store completion.
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign read_data = r_read_data;
    assign mem_done  = r_done;
    assign mem_busy  = r_busy;
    assign mem_err   = r_err_out;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: instance A has two wait states, instance B has none.
// A table of single accesses runs on A; reset-abort and back-to-back cases are hand sequences.
// Strobes are driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_rd, a_wr, b_rd, b_wr;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_done, a_busy, a_err, b_done, b_busy, b_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH(64), .WAIT_CYCLES(2), .DATA_W(32)) dut_a (
        .clk(clk), .reset(reset), .MemRead(a_rd), .MemWrite(a_wr), .addr(a_addr),
        .write_data(a_wdata), .read_data(a_rdata), .mem_done(a_done), .mem_busy(a_busy),
        .mem_err(a_err)
    );

    data_memory_responder #(.DEPTH(64), .WAIT_CYCLES(0), .DATA_W(32)) dut_b (
        .clk(clk), .reset(reset), .MemRead(b_rd), .MemWrite(b_wr), .addr(b_addr),
        .write_data(b_wdata), .read_data(b_rdata), .mem_done(b_done), .mem_busy(b_busy),
        .mem_err(b_err)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            b_rd = rd; b_wr = wr; b_addr = a; b_wdata = wd;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = a; a_wdata = wd;
        end
    endtask

    // One complete access with latency, status, data and return-to-idle checks.
    task automatic access(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic eerr, input logic [31:0] erd, input string nm);
        int lat;
        int exp_lat;
        lat     = 0;
        exp_lat = sel ? 0 : 2;
        @(negedge clk);
        drive(sel, rd, wr, a, wd);
        @(posedge clk); #1;
        check({nm, " busy_at_accept"}, {31'd0, sel ? b_busy : a_busy}, 32'd1);
        @(negedge clk);
        // Scramble the inputs so any use of unlatched values shows up.
        drive(sel, 1'b0, 1'b0, 32'h0000_0003, 32'h5A5A_5A5A);
        while (((sel ? b_done : a_done) !== 1'b1) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " err"}, {31'd0, sel ? b_err : a_err}, {31'd0, eerr});
        check({nm, " rdata"}, sel ? b_rdata : a_rdata, erd);
        check({nm, " busy_in_done"}, {31'd0, sel ? b_busy : a_busy}, 32'd1);
        @(posedge clk); #1;
        check({nm, " done_cleared"}, {31'd0, sel ? b_done : a_done}, 32'd0);
        check({nm, " rdata_cleared"}, sel ? b_rdata : a_rdata, 32'd0);
        check({nm, " idle"}, {31'd0, sel ? b_busy : a_busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_done;

        //           rd    wr    addr           wdata          err   rdata
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h2222_2222, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h3333_3333, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0100, 32'hBAD0_BAD0, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1111_1111};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h2222_2222};
        vecs[12] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 32'h8000_0004, 32'h7777_7777, 1'b1, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h2222_2222};
        vecs[15] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset a_rdata", a_rdata, 32'h0);
        check("reset a_done", {31'd0, a_done}, 32'd0);
        check("reset a_busy", {31'd0, a_busy}, 32'd0);
        check("reset a_err", {31'd0, a_err}, 32'd0);
        check("reset b_rdata", b_rdata, 32'h0);
        check("reset b_done", {31'd0, b_done}, 32'd0);
        check("reset b_busy", {31'd0, b_busy}, 32'd0);
        check("reset b_err", {31'd0, b_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            access(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end

        // Reset while BUSY: the store must be dropped and no completion appear.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678);
        @(posedge clk); #1;
        check("rst_busy accepted", {31'd0, a_busy}, 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_busy busy", {31'd0, a_busy}, 32'd0);
        check("rst_busy done", {31'd0, a_done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen_done = seen_done | a_done;
        end
        check("rst_busy no_done_after", {31'd0, seen_done}, 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h3333_3333, "rst_busy reload");

        // Reset while DONE: completion is cut short and the store never lands.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h5555_5555);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        check("rst_done in_done", {31'd0, a_done}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_done done", {31'd0, a_done}, 32'd0);
        check("rst_done busy", {31'd0, a_busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'h3333_3333, "rst_done reload");

        // Zero wait states: back-to-back stores, with a pulse during DONE ignored.
        access(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'hCCCC_0003, 1'b0, 32'h0, "b prep");
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'hAAAA_0001);
        @(posedge clk); #1;
        check("b2b first done", {31'd0, b_done}, 32'd1);
        check("b2b first err", {31'd0, b_err}, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'hDEAD_DEAD);
        @(posedge clk); #1;
        check("b2b ignored busy", {31'd0, b_busy}, 32'd0);
        check("b2b ignored done", {31'd0, b_done}, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0004, 32'hBBBB_0002);
        @(posedge clk); #1;
        check("b2b second done", {31'd0, b_done}, 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("b2b second idle", {31'd0, b_busy}, 32'd0);
        access(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'hAAAA_0001, "b read w0");
        access(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'hBBBB_0002, "b read w1");
        access(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, 32'hCCCC_0003, "b read w2");
        access(1'b1, 1'b1, 1'b0, 32'h0000_0101, 32'h0, 1'b1, 32'h0, "b bad addr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
